// File: rtl/fp_leading_one_pipe.sv
// Pipelined leading/trailing one/zero counter with valid/ready handshake and sideband tag.
// Optional normalising shifter on the last stage when FP_LOP_NORM_EN is defined.
module fp_leading_one_pipe #(
  parameter int unsigned LEN         = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [LEN-1:0]          data_i,
  input  logic                    from_lsb_i,
  input  logic                    zeros_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [$clog2(LEN)-1:0]  cnt_o,
  output logic                    empty_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [LEN-1:0]          norm_o
);

  localparam int unsigned CW     = $clog2(LEN);
  localparam int unsigned LEVELS = CW;
  localparam int unsigned PAD    = 1 << CW;
  localparam int unsigned NODES  = 2 * PAD - 1;
  localparam int unsigned ROOT   = NODES - 1;

  // Flat node numbering: level l starts at 2*PAD - 2*(PAD>>l), leaves first.
  function automatic int unsigned lvl_off(input int unsigned l);
    return 2 * PAD - 2 * (PAD >> l);
  endfunction

  // Register s sits after tree level (s*LEVELS)/PIPE_STAGES, so the last one is at the root.
  function automatic logic [LEVELS:0] calc_reg_lvl();
    logic [LEVELS:0] r;
    r = '0;
    for (int unsigned s = 1; s <= PIPE_STAGES; s++) r[(s * LEVELS) / PIPE_STAGES] = 1'b1;
    return r;
  endfunction

  function automatic int unsigned stage_of(input int unsigned l);
    int unsigned n;
    n = 0;
    for (int unsigned s = 1; s <= PIPE_STAGES; s++)
      if ((s * LEVELS) / PIPE_STAGES <= l) n++;
    return (n == 0) ? 0 : n - 1;
  endfunction

  localparam logic [LEVELS:0] REG_LVL = calc_reg_lvl();

`ifdef FP_LOP_NORM_EN
  function automatic logic [LEN-1:0] do_norm(input logic [LEN-1:0] d, input logic lsb,
                                             input logic f, input logic [CW-1:0] c);
    if (!f) return d;
    return lsb ? (d >> c) : (d << c);
  endfunction
`endif

  logic [LEN-1:0] x;
  logic [PAD-1:0] x_pad;
  logic           found_c [NODES];
  logic [CW-1:0]  idx_c   [NODES];
  logic           found_r [NODES];
  logic [CW-1:0]  idx_r   [NODES];

  // Operand prep: invert for zero search, reverse so the tree always scans from index 0.
  always_comb begin
    x = '0;
    for (int unsigned i = 0; i < LEN; i++)
      x[i] = (from_lsb_i ? data_i[i] : data_i[LEN-1-i]) ^ zeros_i;
    x_pad = PAD'(x);
  end

  // Priority tree: lower index wins; index forced to 0 when no leaf below matches.
  always_comb begin
    int unsigned   ci, ni;
    logic          fl, fr;
    logic [CW-1:0] il, ir;
    ci = 0; ni = 0; fl = 1'b0; fr = 1'b0; il = '0; ir = '0;
    found_c = '{default: 1'b0};
    idx_c   = '{default: '0};
    for (int unsigned i = 0; i < PAD; i++) begin
      found_c[i] = x_pad[i];
      idx_c[i]   = CW'(i);
    end
    for (int unsigned l = 1; l <= LEVELS; l++) begin
      for (int unsigned j = 0; j < (PAD >> l); j++) begin
        ci = lvl_off(l - 1) + 2 * j;
        ni = lvl_off(l) + j;
        fl = REG_LVL[l-1] ? found_r[ci]     : found_c[ci];
        fr = REG_LVL[l-1] ? found_r[ci + 1] : found_c[ci + 1];
        il = REG_LVL[l-1] ? idx_r[ci]       : idx_c[ci];
        ir = REG_LVL[l-1] ? idx_r[ci + 1]   : idx_c[ci + 1];
        found_c[ni] = fl | fr;
        idx_c[ni]   = fl ? il : (fr ? ir : '0);
      end
    end
  end

  if (PIPE_STAGES == 0) begin : g_comb
    always_comb begin
      found_r = '{default: 1'b0};
      idx_r   = '{default: '0};
    end
    assign ready_o = ready_i;
    assign valid_o = valid_i;
    assign cnt_o   = idx_c[ROOT];
    assign empty_o = ~found_c[ROOT];
    assign tag_o   = tag_i;
`ifdef FP_LOP_NORM_EN
    assign norm_o  = do_norm(data_i, from_lsb_i, found_c[ROOT], idx_c[ROOT]);
`else
    assign norm_o  = '0;
`endif
  end else begin : g_pipe
    logic                   live;
    logic                   nxt;
    logic [PIPE_STAGES-1:0] vq, vin, en, ld;
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_in [PIPE_STAGES];
`ifdef FP_LOP_NORM_EN
    logic [LEN-1:0]         dat_q  [PIPE_STAGES];
    logic [LEN-1:0]         dat_in [PIPE_STAGES];
    logic                   lsb_q  [PIPE_STAGES];
    logic                   lsb_in [PIPE_STAGES];
`endif

    // Stage enables ripple back from the output; stage 0 also waits for reset release.
    always_comb begin
      en  = '0;
      nxt = ready_i;
      vin = PIPE_STAGES'({vq, valid_i});
      for (int s = int'(PIPE_STAGES) - 1; s >= 0; s--) begin
        en[s] = ~vq[s] | nxt;
        nxt   = en[s];
      end
      en[0] = en[0] & live;
      ld    = en & vin;
    end

    always_comb begin
      tag_in    = '{default: '0};
      tag_in[0] = tag_i;
      for (int unsigned s = 1; s < PIPE_STAGES; s++) tag_in[s] = tag_q[s-1];
`ifdef FP_LOP_NORM_EN
      dat_in    = '{default: '0};
      lsb_in    = '{default: 1'b0};
      dat_in[0] = data_i;
      lsb_in[0] = from_lsb_i;
      for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
        dat_in[s] = dat_q[s-1];
        lsb_in[s] = lsb_q[s-1];
      end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        live  <= 1'b0;
        vq    <= '0;
        tag_q <= '{default: '0};
`ifdef FP_LOP_NORM_EN
        dat_q <= '{default: '0};
        lsb_q <= '{default: 1'b0};
`endif
      end else begin
        live <= 1'b1;
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
          if (en[s]) vq[s] <= vin[s];
          if (ld[s]) begin
            tag_q[s] <= tag_in[s];
`ifdef FP_LOP_NORM_EN
            // Last stage holds the shifted operand instead of the raw one.
            dat_q[s] <= (s == PIPE_STAGES - 1)
                        ? do_norm(dat_in[s], lsb_in[s], found_c[ROOT], idx_c[ROOT])
                        : dat_in[s];
            lsb_q[s] <= lsb_in[s];
`endif
          end
        end
      end
    end

    // Tree node registers, loaded only with a real beat so outputs hold between beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        found_r <= '{default: 1'b0};
        idx_r   <= '{default: '0};
      end else begin
        for (int unsigned l = 1; l <= LEVELS; l++) begin
          if (REG_LVL[l]) begin
            for (int unsigned j = 0; j < (PAD >> l); j++) begin
              if (ld[stage_of(l)]) begin
                found_r[lvl_off(l) + j] <= found_c[lvl_off(l) + j];
                idx_r[lvl_off(l) + j]   <= idx_c[lvl_off(l) + j];
              end
            end
          end
        end
      end
    end

    assign ready_o = en[0];
    assign valid_o = vq[PIPE_STAGES-1];
    assign cnt_o   = idx_r[ROOT];
    assign empty_o = ~found_r[ROOT];
    assign tag_o   = tag_q[PIPE_STAGES-1];
`ifdef FP_LOP_NORM_EN
    assign norm_o  = dat_q[PIPE_STAGES-1];
`else
    assign norm_o  = '0;
`endif
  end

endmodule

// File: tb/tb_fp_leading_one_pipe.sv
// Directed bench: 2-stage 32-bit instance plus a combinational 24-bit instance.
module tb_fp_leading_one_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_valid, a_ready, a_lsb, a_zeros, a_vo, a_ri, a_empty;
  logic [31:0] a_data, a_norm;
  logic [3:0]  a_tag, a_tago;
  logic [4:0]  a_cnt;

  logic        b_valid, b_ready, b_lsb, b_zeros, b_vo, b_ri, b_empty;
  logic [23:0] b_data, b_norm;
  logic [3:0]  b_tag, b_tago;
  logic [4:0]  b_cnt;

  fp_leading_one_pipe #(.LEN(32), .PIPE_STAGES(2), .TAG_W(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid), .ready_o(a_ready), .data_i(a_data),
    .from_lsb_i(a_lsb), .zeros_i(a_zeros), .tag_i(a_tag), .valid_o(a_vo), .ready_i(a_ri),
    .cnt_o(a_cnt), .empty_o(a_empty), .tag_o(a_tago), .norm_o(a_norm));

  fp_leading_one_pipe #(.LEN(24), .PIPE_STAGES(0), .TAG_W(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid), .ready_o(b_ready), .data_i(b_data),
    .from_lsb_i(b_lsb), .zeros_i(b_zeros), .tag_i(b_tag), .valid_o(b_vo), .ready_i(b_ri),
    .cnt_o(b_cnt), .empty_o(b_empty), .tag_o(b_tago), .norm_o(b_norm));

  // 32-bit vectors: data, from_lsb, zeros, expected cnt, expected empty
  logic [31:0] va_d [12] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                             32'hFFF0_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001,
                             32'h0000_0001, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
  logic        va_l [12] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1};
  logic        va_z [12] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
  logic [4:0]  va_c [12] = '{15, 16, 0, 0, 12, 0, 31, 0, 31, 0, 0, 31};
  logic        va_e [12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  logic [23:0] vb_d [7] = '{24'h000001, 24'hFFFFFF, 24'h800000, 24'h800000,
                            24'h000100, 24'hFFFFFE, 24'h000000};
  logic        vb_l [7] = '{0, 0, 0, 1, 1, 0, 1};
  logic        vb_z [7] = '{0, 1, 0, 0, 0, 1, 0};
  logic [4:0]  vb_c [7] = '{23, 0, 0, 23, 8, 23, 0};
  logic        vb_e [7] = '{0, 1, 0, 0, 0, 0, 1};

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_ri = 1'b1; a_data = '0; a_lsb = 1'b0; a_zeros = 1'b0; a_tag = '0;
    b_valid = 1'b0; b_ri = 1'b1; b_data = '0; b_lsb = 1'b0; b_zeros = 1'b0; b_tag = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_vo); end
    n_tests++; if (a_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    n_tests++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", a_empty); end
    n_tests++; if (a_tago !== 4'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", a_tago); end
    n_tests++; if (a_norm !== 32'd0) begin n_fail++; $display("FAIL reset_norm: got %h want 0", a_norm); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_single();
    logic [31:0] en;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      a_ri = 1'b1; a_valid = 1'b1; a_data = va_d[k]; a_lsb = va_l[k]; a_zeros = va_z[k];
      a_tag = 4'(k + 3);
`ifdef FP_LOP_NORM_EN
      en = va_e[k] ? va_d[k] : (va_l[k] ? (va_d[k] >> va_c[k]) : (va_d[k] << va_c[k]));
`else
      en = 32'd0;
`endif
      @(negedge clk);
      a_valid = 1'b0;
      n_tests++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL single_early[%0d]: valid %b want 0", k, a_vo); end
      @(negedge clk);
      n_tests++; if (a_vo !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b want 1", k, a_vo); end
      n_tests++; if (a_cnt !== va_c[k]) begin n_fail++; $display("FAIL single_cnt[%0d]: got %0d want %0d", k, a_cnt, va_c[k]); end
      n_tests++; if (a_empty !== va_e[k]) begin n_fail++; $display("FAIL single_empty[%0d]: got %b want %b", k, a_empty, va_e[k]); end
      n_tests++; if (a_tago !== 4'(k + 3)) begin n_fail++; $display("FAIL single_tag[%0d]: got %0d want %0d", k, a_tago, k + 3); end
      n_tests++; if (a_norm !== en) begin n_fail++; $display("FAIL single_norm[%0d]: got %h want %h", k, a_norm, en); end
      @(negedge clk);
      n_tests++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL single_drain[%0d]: valid %b want 0", k, a_vo); end
      n_tests++; if (a_cnt !== va_c[k]) begin n_fail++; $display("FAIL single_hold[%0d]: cnt %0d want %0d", k, a_cnt, va_c[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int   sent, got;
    logic saw_full;
    sent = 0; got = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      a_ri = !(cyc >= 3 && cyc <= 7);
      if (sent < 8) begin
        a_valid = 1'b1; a_data = 32'h1 << (3 * sent); a_lsb = 1'b0; a_zeros = 1'b0; a_tag = 4'(sent);
      end else begin
        a_valid = 1'b0;
      end
      #1;
      if (!a_ready) saw_full = 1'b1;
      if (cyc >= 4 && cyc <= 7) begin
        n_tests++; if (a_vo !== 1'b1 || a_tago !== 4'(got)) begin
          n_fail++; $display("FAIL stall_hold[%0d]: valid %b tag %0d want 1 tag %0d", cyc, a_vo, a_tago, got);
        end
      end
      if (a_vo && a_ri) begin
        n_tests++; if (a_tago !== 4'(got) || a_cnt !== 5'(31 - 3 * got)) begin
          n_fail++; $display("FAIL stream_beat[%0d]: tag %0d cnt %0d want tag %0d cnt %0d", got, a_tago, a_cnt, got, 31 - 3 * got);
        end
        got++;
      end
      if (a_valid && a_ready) sent++;
    end
    a_valid = 1'b0;
    n_tests++; if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d beats want 8", got); end
    n_tests++; if (saw_full !== 1'b1) begin n_fail++; $display("FAIL stream_backpressure: ready_o never 0, want 0 when full"); end
  endtask

  task automatic test_reset_mid();
    int ghosts;
    ghosts = 0;
    @(negedge clk);
    a_ri = 1'b0; a_valid = 1'b1; a_data = 32'h0000_0100; a_tag = 4'd1;
    @(negedge clk);
    a_tag = 4'd2;
    @(negedge clk);
    a_valid = 1'b0;
    n_tests++; if (a_vo !== 1'b1) begin n_fail++; $display("FAIL mid_inflight: valid %b want 1", a_vo); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (a_vo !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", a_vo); end
    @(negedge clk);
    rst_n = 1'b1; a_ri = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_vo) ghosts++;
    end
    n_tests++; if (ghosts != 0) begin n_fail++; $display("FAIL mid_ghost: %0d output beats want 0", ghosts); end
  endtask

  task automatic test_comb();
    logic [23:0] en;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      b_valid = 1'b1; b_ri = 1'b1; b_data = vb_d[k]; b_lsb = vb_l[k]; b_zeros = vb_z[k]; b_tag = 4'(k + 8);
`ifdef FP_LOP_NORM_EN
      en = vb_e[k] ? vb_d[k] : (vb_l[k] ? (vb_d[k] >> vb_c[k]) : (vb_d[k] << vb_c[k]));
`else
      en = 24'd0;
`endif
      #1;
      n_tests++; if (b_cnt !== vb_c[k]) begin n_fail++; $display("FAIL comb_cnt[%0d]: got %0d want %0d", k, b_cnt, vb_c[k]); end
      n_tests++; if (b_empty !== vb_e[k]) begin n_fail++; $display("FAIL comb_empty[%0d]: got %b want %b", k, b_empty, vb_e[k]); end
      n_tests++; if (b_tago !== 4'(k + 8) || b_vo !== 1'b1) begin n_fail++; $display("FAIL comb_tag[%0d]: tag %0d valid %b want %0d 1", k, b_tago, b_vo, k + 8); end
      n_tests++; if (b_norm !== en) begin n_fail++; $display("FAIL comb_norm[%0d]: got %h want %h", k, b_norm, en); end
    end
    @(negedge clk);
    b_ri = 1'b0; b_valid = 1'b0;
    #1;
    n_tests++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL comb_ready: got %b want 0", b_ready); end
    n_tests++; if (b_vo !== 1'b0) begin n_fail++; $display("FAIL comb_valid: got %b want 0", b_vo); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_comb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
